muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit executing the HI/LO operations issued by the decode stage: MULT, MULTU, DIV, DIVU, MTHI, MTLO. It sits in the execute stage beside the ALU and owns the architectural HI and LO registers. It holds `busy` while an operation is in flight so the pipeline stalls any later HI/LO consumer. MFHI/MFLO read `hi`/`lo` directly.

## Interface
- (no parameters; operand width fixed at 32, iteration count fixed at 32)
- `clk` in 1: single clock, all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request to begin the op given by `op`. Sampled only in IDLE.
- `op` in 4: execute function code. 4'b1011 MULT, 4'b1100 MULTU, 4'b1101 DIV, 4'b1110 DIVU. Any other code with `start` is ignored.
- `a` in 32: rs value (multiplicand / dividend).
- `b` in 32: rt value (multiplier / divisor).
- `hi_write` in 1: MTHI strobe.
- `lo_write` in 1: MTLO strobe.
- `wdata` in 32: rs value for MTHI/MTLO.
- `cancel` in 1: pipeline flush; aborts the in-flight op.
- `busy` out 1: high whenever state is not IDLE.
- `done` out 1: one-cycle pulse in the first cycle that `hi`/`lo` show a new op result.
- `hi` out 32: HI register.
- `lo` out 32: LO register.

## Operation
- **States:** IDLE, RUN, FIN.
- **IDLE + `start` + valid `op`:**
  - Latch the op and the signs `sa`=a[31], `sb`=b[31]. Signs count only for MULT/DIV; they are 0 for the unsigned ops.
  - Latch the operand magnitudes, using two's-complement negation when the sign is set.
  - Clear the iteration counter and go to RUN.
- **RUN:** one iteration per cycle on the unsigned magnitudes.
  - Multiply: 64-bit shift-add.
  - Divide: restoring shift-subtract producing a 32-bit quotient and remainder.
  - Counter runs 0..31. At count 31, go to FIN.
- **FIN:** sign correction, then write HI/LO, pulse `done`, return to IDLE.
  - MULT: the 64-bit product is negated if `sa`^`sb`. HI = prod[63:32], LO = prod[31:0].
  - DIV: the quotient is negated if `sa`^`sb`, and the remainder is negated if `sa`. LO = quotient, HI = remainder.
  - Divide by zero (DIV or DIVU): LO = 32'hFFFFFFFF and HI = the original `a`, overriding the iteration result.
  - DIV 32'h80000000 / 32'hFFFFFFFF gives LO = 32'h80000000, HI = 0, with no exception.
- **MTHI/MTLO:**
  - In IDLE, `hi_write`/`lo_write` load `wdata` into HI/LO at the edge.
  - If `start` is also high in the same cycle, the write still applies. The op's FIN write later overwrites it.
  - While busy, `hi_write`/`lo_write` are ignored. Decode stalls them on `busy`.
- **`start` while busy:** ignored, with no effect on the running op.
- **`cancel`:** in RUN or FIN, the next edge returns to IDLE. HI/LO keep their values and `done` stays 0. It has priority over the FIN write. In IDLE it has no effect, and `start` is not accepted in the same cycle.
- **Reset (including mid-op):** state IDLE, `hi`=0, `lo`=0, `done`=0, `busy`=0, counter=0.

## Timing
- Acceptance edge E0 (IDLE, `start`=1).
- `busy` is 1 in cycles E0+1 through E0+33. The RUN iterations occur at edges E0+1..E0+32.
- The FIN edge is E0+33: `hi`/`lo` update, `done`=1 for one cycle, `busy`=0.
- A new `start` can be accepted at edge E0+33, back-to-back with `done`.
- Fixed latency of 33 cycles for every op, including divide by zero.
- `hi`/`lo` are registered outputs with no combinational path from the inputs.

## Test plan
- MULTU a=FFFFFFFF b=FFFFFFFF -> at E0+33, HI=FFFFFFFE, LO=00000001, `done`=1 for exactly one cycle, `busy` high for exactly 33 cycles.
- MULT a=FFFFFFFD (-3) b=00000007 -> HI=FFFFFFFF, LO=FFFFFFEB. DIV a=FFFFFFF9 (-7) b=00000002 -> LO=FFFFFFFD, HI=FFFFFFFF.
- DIVU a=00000064 b=0 -> LO=FFFFFFFF, HI=00000064. DIV a=80000000 b=FFFFFFFF -> LO=80000000, HI=00000000.
- MTHI wdata=12345678 in IDLE -> HI=12345678 next cycle. Then MULTU 2×3 -> HI=0, LO=6. A `hi_write` issued mid-op is ignored and leaves HI=0.
- HI=LO=AAAAAAAA, start DIVU, assert `cancel` at E0+10 -> `busy`=0 from E0+11, no `done`, HI/LO stay AAAAAAAA. A `start` pulse mid-op is ignored and the result is unchanged.
- Assert `reset` at E0+20 -> next cycle `busy`=0, `hi`=`lo`=0, `done`=0. A fresh MULTU 5×5 completes in 33 cycles with LO=25.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit multiply/divide unit that owns the architectural HI/LO registers.
// Fixed 33-cycle latency: 32 RUN iterations on magnitudes, then one FIN cycle for sign fix and writeback.
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_write,
  input  logic        lo_write,
  input  logic [31:0] wdata,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned W  = 32;
  localparam int unsigned DW = 2 * W;
  localparam int unsigned CW = 5;

  localparam logic [3:0] OP_MULT  = 4'b1011;
  localparam logic [3:0] OP_MULTU = 4'b1100;
  localparam logic [3:0] OP_DIV   = 4'b1101;
  localparam logic [3:0] OP_DIVU  = 4'b1110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            is_div_q, is_div_d;
  logic            sa_q, sa_d;
  logic            sb_q, sb_d;
  logic            bzero_q, bzero_d;
  logic [W-1:0]    a_orig_q, a_orig_d;
  logic [W-1:0]    opnd_q, opnd_d;
  logic [DW-1:0]   acc_q, acc_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [W-1:0]    hi_q, hi_d;
  logic [W-1:0]    lo_q, lo_d;

  logic            op_valid_c, signed_op_c, div_op_c;
  logic            sa_c, sb_c;
  logic [W-1:0]    mag_a_c, mag_b_c;
  logic [W:0]      mul_sum_c;
  logic [W:0]      div_shift_c, div_diff_c;
  logic [DW-1:0]   prod_neg_c;
  logic [W-1:0]    quo_neg_c, rem_neg_c;

  // Operand decode and magnitude extraction for a newly issued op
  always_comb begin
    op_valid_c  = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    signed_op_c = (op == OP_MULT) || (op == OP_DIV);
    div_op_c    = (op == OP_DIV) || (op == OP_DIVU);
    sa_c        = signed_op_c & a[W-1];
    sb_c        = signed_op_c & b[W-1];
    mag_a_c     = sa_c ? (~a) + W'(1) : a;
    mag_b_c     = sb_c ? (~b) + W'(1) : b;
  end

  // One iteration step; acc holds {upper, lower} for multiply and {remainder, quotient} for divide
  always_comb begin
    mul_sum_c   = {1'b0, acc_q[DW-1:W]} + {1'b0, (acc_q[0] ? opnd_q : W'(0))};
    div_shift_c = {acc_q[DW-1:W], acc_q[W-1]};
    div_diff_c  = div_shift_c - {1'b0, opnd_q};
    prod_neg_c  = (~acc_q) + DW'(1);
    quo_neg_c   = (~acc_q[W-1:0]) + W'(1);
    rem_neg_c   = (~acc_q[DW-1:W]) + W'(1);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    bzero_d  = bzero_q;
    a_orig_d = a_orig_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;

    unique case (state_q)
      S_IDLE: begin
        if (hi_write) hi_d = wdata;
        if (lo_write) lo_d = wdata;
        if (start && op_valid_c && !cancel) begin
          is_div_d = div_op_c;
          sa_d     = sa_c;
          sb_d     = sb_c;
          bzero_d  = (b == W'(0));
          a_orig_d = a;
          opnd_d   = div_op_c ? mag_b_c : mag_a_c;
          acc_d    = {W'(0), (div_op_c ? mag_a_c : mag_b_c)};
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          if (is_div_q) begin
            if (!div_diff_c[W]) acc_d = {div_diff_c[W-1:0], acc_q[W-2:0], 1'b1};
            else                acc_d = {div_shift_c[W-1:0], acc_q[W-2:0], 1'b0};
          end else begin
            acc_d = {mul_sum_c, acc_q[W-1:1]};
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(W - 1)) state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        if (!cancel) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            {hi_d, lo_d} = (sa_q ^ sb_q) ? prod_neg_c : acc_q;
          end else if (bzero_q) begin
            lo_d = '1;
            hi_d = a_orig_q;
          end else begin
            lo_d = (sa_q ^ sb_q) ? quo_neg_c : acc_q[W-1:0];
            hi_d = sa_q ? rem_neg_c : acc_q[DW-1:W];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      bzero_q  <= 1'b0;
      a_orig_q <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      bzero_q  <= bzero_d;
      a_orig_q <= a_orig_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: arithmetic reference model compared every cycle,
// plus directed vectors with hand-computed HI/LO, latency and control-corner expectations.
module tb_muldiv_unit;

  localparam logic [3:0] OP_MULT  = 4'b1011;
  localparam logic [3:0] OP_MULTU = 4'b1100;
  localparam logic [3:0] OP_DIV   = 4'b1101;
  localparam logic [3:0] OP_DIVU  = 4'b1110;

  logic        clk = 1'b0;
  logic        reset, start, hi_write, lo_write, cancel;
  logic [3:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_write(hi_write), .lo_write(lo_write), .wdata(wdata), .cancel(cancel),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Expected {HI, LO} from plain arithmetic on the architectural operands
  function automatic logic [63:0] ref_result(input logic [3:0] f, input logic [31:0] x, input logic [31:0] y);
    longint          sp;
    longint unsigned up;
    int              sx, sy;
    sx = x;
    sy = y;
    case (f)
      OP_MULT: begin
        sp = longint'(sx) * longint'(sy);
        return sp;
      end
      OP_MULTU: begin
        up = {32'h0, x} * {32'h0, y};
        return up;
      end
      OP_DIV: begin
        if (y == 32'h0) return {x, 32'hFFFFFFFF};
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        return {32'(sx % sy), 32'(sx / sy)};
      end
      OP_DIVU: begin
        if (y == 32'h0) return {x, 32'hFFFFFFFF};
        return {x % y, x / y};
      end
      default: return 64'h0;
    endcase
  endfunction

  // Cycle-level behavioural model: a countdown of remaining busy cycles and pending result
  int          m_left = 0;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  logic        m_done;

  always @(posedge clk) begin
    if (reset) begin
      m_left = 0;
      m_hi   = 32'h0;
      m_lo   = 32'h0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        if (cancel) begin
          m_left = 0;
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_hi   = p_hi;
            m_lo   = p_lo;
            m_done = 1'b1;
          end
        end
      end else begin
        if (hi_write) m_hi = wdata;
        if (lo_write) m_lo = wdata;
        if (start && !cancel && (op == OP_MULT || op == OP_MULTU || op == OP_DIV || op == OP_DIVU)) begin
          {p_hi, p_lo} = ref_result(op, a, b);
          m_left = 33;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy", 64'(busy), 64'(m_left > 0));
      check("cyc_done", 64'(done), 64'(m_done));
      check("cyc_hi", 64'(hi), 64'(m_hi));
      check("cyc_lo", 64'(lo), 64'(m_lo));
    end
  end

  int op_k;
  int op_nbusy;

  task automatic tick();
    if (busy) op_nbusy++;
    @(negedge clk);
    op_k++;
  endtask

  task automatic issue(input logic [3:0] f, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = f;
    a     = x;
    b     = y;
    @(negedge clk);
    start    = 1'b0;
    op       = 4'h0;
    a        = 32'h0;
    b        = 32'h0;
    op_k     = 0;
    op_nbusy = 0;
  endtask

  task automatic wait_done(input string name, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    while (!done && op_k < 40) tick();
    check({name, "_latency"}, 64'(op_k), 64'd33);
    check({name, "_busy_cycles"}, 64'(op_nbusy), 64'd33);
    check({name, "_busy_at_done"}, 64'(busy), 64'd0);
    check({name, "_hi"}, 64'(hi), 64'(exp_hi));
    check({name, "_lo"}, 64'(lo), 64'(exp_lo));
    @(negedge clk);
    check({name, "_done_one_cycle"}, 64'(done), 64'd0);
  endtask

  task automatic run_op(input string name, input logic [3:0] f, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    issue(f, x, y);
    wait_done(name, exp_hi, exp_lo);
  endtask

  initial begin
    int n_done;
    reset = 1'b1; start = 1'b0; op = 4'h0; a = 32'h0; b = 32'h0;
    hi_write = 1'b0; lo_write = 1'b0; wdata = 32'h0; cancel = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_neg", OP_MULT, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("div_neg", OP_DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu_zero", OP_DIVU, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF);
    run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_op("div_zero", OP_DIV, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF);
    run_op("divu_big", OP_DIVU, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF);

    // MTHI in idle, then a mid-op HI write that must be dropped
    hi_write = 1'b1; wdata = 32'h12345678;
    @(negedge clk);
    hi_write = 1'b0;
    check("mthi_idle", 64'(hi), 64'h12345678);
    issue(OP_MULTU, 32'h2, 32'h3);
    repeat (9) tick();
    hi_write = 1'b1; wdata = 32'hDEADBEEF;
    tick();
    hi_write = 1'b0;
    wait_done("multu_2x3", 32'h0, 32'h6);

    // Cancel mid-op leaves HI/LO untouched and never pulses done
    hi_write = 1'b1; lo_write = 1'b1; wdata = 32'hAAAAAAAA;
    @(negedge clk);
    hi_write = 1'b0; lo_write = 1'b0;
    check("mt_both", 64'({hi, lo}), 64'hAAAAAAAA_AAAAAAAA);
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (9) tick();
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_busy", 64'(busy), 64'd0);
    n_done = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) n_done++;
      @(negedge clk);
    end
    check("cancel_no_done", 64'(n_done), 64'd0);
    check("cancel_hilo", 64'({hi, lo}), 64'hAAAAAAAA_AAAAAAAA);

    // A start pulse while busy must not disturb the running op
    issue(OP_MULTU, 32'h1234, 32'h5678);
    repeat (4) tick();
    start = 1'b1; op = OP_DIV; a = 32'hFFFFFFFF; b = 32'h3;
    tick();
    start = 1'b0; op = 4'h0; a = 32'h0; b = 32'h0;
    wait_done("start_busy", 32'h0, 32'h06260060);

    // Unsupported function code and cancel-in-idle both block acceptance
    issue(4'b1010, 32'h5, 32'h5);
    check("badop_busy", 64'(busy), 64'd0);
    cancel = 1'b1;
    issue(OP_MULTU, 32'h5, 32'h5);
    cancel = 1'b0;
    check("cancel_idle_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);

    // Reset mid-op clears everything, then a fresh op runs normally
    issue(OP_MULTU, 32'hFFFFFFFF, 32'h2);
    repeat (19) tick();
    reset = 1'b1;
    @(negedge clk);
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_done", 64'(done), 64'd0);
    check("midreset_hilo", 64'({hi, lo}), 64'h0);
    reset = 1'b0;
    @(negedge clk);
    run_op("multu_5x5", OP_MULTU, 32'h5, 32'h5, 32'h0, 32'h19);

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
